bpsk_rx_deframer: RTL

Receive-side deframer for the BPSK link. It sits after the per-channel AD delay lines and takes delayed 8-bit offset-binary samples from both AD channels, with a frame-aligned valid. It integrates each symbol per lane, hunts for a sync word on lane 1, and assembles the 128-bit payload that follows. Each completed word is pushed into the receive FIFO through a wr_en/full interface.

---
 rtl/comm_pkg.sv | 14 +
 rtl/bpsk_rx_deframer_if.sv | 17 +
 rtl/bpsk_slicer.sv | 34 +++
 rtl/bpsk_rx_deframer.sv | 115 +++++++++++
 4 files changed

// File: rtl/comm_pkg.sv
// Shared BPSK link definitions: deframer state encoding, default sync
// pattern (also used by the transmit framer) and payload geometry.
package comm_pkg;

   typedef enum logic {
      HUNT    = 1'b0,
      PAYLOAD = 1'b1
   } state_t;

   localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hD391;
   localparam int          PAYLOAD_SYMS      = 64;
   localparam int          WORD_W            = 128;

endpackage

// File: rtl/bpsk_rx_deframer_if.sv
// Sample stream in and FIFO write port out of the receive deframer.
// Samples: ad_valid qualifies ad1/ad2 each cycle; its rising edge starts a symbol.
// FIFO: wr_en is a one-cycle write of dout, issued only when full was low.
interface bpsk_rx_deframer_if;
   import comm_pkg::*;

   logic [7:0]        ad1;
   logic [7:0]        ad2;
   logic              ad_valid;
   logic [WORD_W-1:0] dout;
   logic              wr_en;
   logic              full;

   modport slave  (input  ad1, ad2, ad_valid, full, output dout, wr_en);
   modport master (output ad1, ad2, ad_valid, full, input  dout, wr_en);

endinterface

// File: rtl/bpsk_slicer.sv
// One lane of integrate-and-dump: offset-binary to signed conversion,
// per-symbol accumulation and a sign decision on the last sample.
module bpsk_slicer #(
   parameter int SPS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] sample,
   input  logic       valid,
   input  logic       last,
   output logic       bit_out,
   output logic       strobe
);

   localparam int ACC_W = 8 + $clog2(SPS);

   logic signed [7:0]       s;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] sum;

   assign s   = signed'(sample ^ 8'h80);
   // Width holds SPS full-scale samples, so the sum cannot wrap.
   assign sum = acc + ACC_W'(s);

   assign strobe  = valid & last;
   assign bit_out = ~sum[ACC_W-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               acc <= '0;
      else if (!valid || last)  acc <= '0;
      else                      acc <= sum;
   end

endmodule

// File: rtl/bpsk_rx_deframer.sv
// BPSK receive deframer: slices both lanes, hunts for the sync word on
// lane 1 and assembles the following 64 two-bit symbols into a FIFO word.
module bpsk_rx_deframer
   import comm_pkg::*;
#(
   parameter int          SPS       = 4,
   parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEFAULT
) (
   input  logic               CLK,
   input  logic               RST,
   bpsk_rx_deframer_if.slave  bus,
   output logic               locked,
   output logic               overflow,
   output logic               frame_err,
   output state_t             dbg_state
);

   localparam int CNT_W = $clog2(SPS);

   state_t            state, state_next;
   logic [CNT_W-1:0]  cnt;
   logic              last;
   logic              b1, b2, stb1, stb2, sym_stb;
   logic [15:0]       sync_sr, sync_next;
   logic [WORD_W-1:0] pay_sr, word_next;
   logic [5:0]        sym_cnt;
   logic              last_sym;
   logic              wr_next, ferr_next, ovf_set;

   assign last = bus.ad_valid && (cnt == CNT_W'(SPS - 1));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)                cnt <= '0;
      else if (!bus.ad_valid)  cnt <= '0;
      else if (last)           cnt <= '0;
      else                     cnt <= cnt + 1'b1;
   end

   bpsk_slicer #(.SPS(SPS)) u_slice1 (
      .clk(CLK), .rst_n(RST), .sample(bus.ad1), .valid(bus.ad_valid),
      .last(last), .bit_out(b1), .strobe(stb1)
   );

   bpsk_slicer #(.SPS(SPS)) u_slice2 (
      .clk(CLK), .rst_n(RST), .sample(bus.ad2), .valid(bus.ad_valid),
      .last(last), .bit_out(b2), .strobe(stb2)
   );

   assign sym_stb   = stb1 & stb2;
   assign sync_next = {sync_sr[14:0], b1};
   // Shifting left two bits per symbol leaves symbol 0 in bits 127:126.
   assign word_next = {pay_sr[WORD_W-3:0], b1, b2};
   assign last_sym  = (sym_cnt == 6'(PAYLOAD_SYMS - 1));

   always_comb begin
      state_next = state;
      wr_next    = 1'b0;
      ferr_next  = 1'b0;
      ovf_set    = 1'b0;
      case (state)
         HUNT: begin
            if (sym_stb && sync_next == SYNC_WORD) state_next = PAYLOAD;
         end
         PAYLOAD: begin
            if (!bus.ad_valid) begin
               state_next = HUNT;
               ferr_next  = 1'b1;
            end else if (sym_stb && last_sym) begin
               state_next = HUNT;
               if (!bus.full) wr_next = 1'b1;
               else           ovf_set = 1'b1;
            end
         end
         default: state_next = HUNT;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= HUNT;
      else      state <= state_next;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sync_sr   <= '0;
         pay_sr    <= '0;
         sym_cnt   <= '0;
         bus.dout  <= '0;
         bus.wr_en <= 1'b0;
         frame_err <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         bus.wr_en <= wr_next;
         frame_err <= ferr_next;
         if (ovf_set) overflow <= 1'b1;
         if (wr_next) bus.dout <= word_next;

         // Kept clear through PAYLOAD so HUNT always starts from an empty register.
         if (state != HUNT || !bus.ad_valid || state_next == PAYLOAD) sync_sr <= '0;
         else if (sym_stb)                                            sync_sr <= sync_next;

         if (state != PAYLOAD || state_next != PAYLOAD) begin
            pay_sr  <= '0;
            sym_cnt <= '0;
         end else if (sym_stb) begin
            pay_sr  <= word_next;
            sym_cnt <= sym_cnt + 1'b1;
         end
      end
   end

   assign locked    = (state == PAYLOAD);
   assign dbg_state = state;

endmodule
